// File: rtl/angle_pkg.sv
// Shared types and fixed-point constants for the cosine range-reduction front end.
// All angles are Q.20 fixed point held in 32 bits.
package angle_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    CONVERT = 3'd1,
    REDUCE  = 3'd2,
    FOLD    = 3'd3,
    DONE    = 3'd4
  } state_t;

  localparam logic [31:0] PI_2   = 32'd1647099;
  localparam logic [31:0] PI     = 32'd3294199;
  localparam logic [31:0] PI3_2  = 32'd4941298;
  localparam logic [31:0] TWO_PI = 32'd6588397;

  localparam int EXP_WIDTH  = 8;
  localparam int FRAC_WIDTH = 23;
  localparam int EXP_BIAS   = 127;

  typedef struct packed {
    logic [31:0] scaled;
    logic        sign;
  } fold_t;

  // Maps r in [0, 2*pi) onto [0, pi/2] and returns the sign cos(r) must carry.
  function automatic fold_t fold_angle(input logic [31:0] r);
    fold_t f;
    if (r <= PI_2) begin
      f.scaled = r;
      f.sign   = 1'b0;
    end else if (r < PI) begin
      f.scaled = PI - r;
      f.sign   = 1'b1;
    end else if (r <= PI3_2) begin
      f.scaled = r - PI;
      f.sign   = 1'b1;
    end else begin
      f.scaled = TWO_PI - r;
      f.sign   = 1'b0;
    end
    return f;
  endfunction

endpackage

// File: rtl/delay_counter.sv
// Saturating up-counter: done rises once the count reaches max and holds until rst.
// Shared with the CORDIC engine as its iteration bound.
module delay_counter #(
  parameter int COUNTER_WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [COUNTER_WIDTH-1:0] max,
  output logic                     done
);

  logic [COUNTER_WIDTH-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (count != max) begin
      count <= count + 1'b1;
    end
  end

  assign done = (count == max);

endmodule

// File: rtl/angle_scaler.sv
// Converts an IEEE-754 single angle to Q11.20, reduces it modulo 2*pi and folds it
// into [0, pi/2], reporting the cosine sign; start/done handshake around a small FSM.
module angle_scaler
  import angle_pkg::*;
#(
  parameter int FLOAT_DATA_WIDTH = 32,
  parameter int FRACTIONAL_WIDTH = 20,
  parameter int MAX_EXP          = 6,
  parameter int MAX_REDUCE       = 21
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        clk_en,
  input  logic [FLOAT_DATA_WIDTH-1:0] angle,
  output logic [FLOAT_DATA_WIDTH-1:0] scaled,
  output logic                        sign,
  output logic                        done
);

  localparam logic signed [9:0] MAX_E   = 10'(MAX_EXP);
  localparam logic signed [9:0] MIN_E   = -10'sd24;
  localparam logic signed [9:0] SHIFT_E = 10'(FRAC_WIDTH - FRACTIONAL_WIDTH);

  state_t                        state;
  logic [FLOAT_DATA_WIDTH-2:0]   angle_q;
  logic [FLOAT_DATA_WIDTH-1:0]   mag;
  logic                          oor;

  logic [EXP_WIDTH-1:0]          exp_f;
  logic [FRAC_WIDTH-1:0]         frac_f;
  logic signed [9:0]             e_unb;
  logic [FLOAT_DATA_WIDTH-1:0]   m_ext;
  logic [4:0]                    shamt;
  logic [FLOAT_DATA_WIDTH-1:0]   conv_mag;
  logic                          conv_oor;
  fold_t                         folded;

  logic                          cnt_clr;
  logic                          cnt_done;

  // cos is even, so the input sign bit is dropped
  logic angle_sign_unused;
  assign angle_sign_unused = angle[FLOAT_DATA_WIDTH-1];

  assign exp_f  = angle_q[FRAC_WIDTH +: EXP_WIDTH];
  assign frac_f = angle_q[FRAC_WIDTH-1:0];
  assign e_unb  = $signed({2'b00, exp_f}) - 10'(EXP_BIAS);
  assign m_ext  = {{(FLOAT_DATA_WIDTH-FRAC_WIDTH-1){1'b0}}, 1'b1, frac_f};

  // Float to Q.20: the Q1.23 significand is shifted by e-3, truncating
  always_comb begin
    conv_oor = (exp_f == '1) || (e_unb > MAX_E);
    conv_mag = '0;
    shamt    = '0;
    if (!conv_oor && (exp_f != '0) && (e_unb >= MIN_E)) begin
      if (e_unb >= SHIFT_E) begin
        shamt    = 5'(e_unb - SHIFT_E);
        conv_mag = m_ext << shamt;
      end else begin
        shamt    = 5'(SHIFT_E - e_unb);
        conv_mag = m_ext >> shamt;
      end
    end
  end

  assign folded = fold_angle(mag);

  assign cnt_clr = rst || (state != REDUCE);

  delay_counter #(
    .COUNTER_WIDTH(10)
  ) u_reduce_bound (
    .clk (clk),
    .rst (cnt_clr),
    .max (10'(MAX_REDUCE)),
    .done(cnt_done)
  );

  // Out-of-range inputs still spend one cycle in REDUCE with mag=0, which keeps
  // every result on the same minimum latency
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      angle_q <= '0;
      mag     <= '0;
      oor     <= 1'b0;
      scaled  <= '0;
      sign    <= 1'b0;
      done    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (clk_en) begin
            angle_q <= angle[FLOAT_DATA_WIDTH-2:0];
            state   <= CONVERT;
          end
        end
        CONVERT: begin
          mag   <= conv_mag;
          oor   <= conv_oor;
          state <= REDUCE;
        end
        REDUCE: begin
          if ((mag >= TWO_PI) && !cnt_done) begin
            mag <= mag - TWO_PI;
          end else begin
            state <= FOLD;
          end
        end
        FOLD: begin
          scaled <= oor ? '0 : folded.scaled;
          sign   <= oor ? 1'b0 : folded.sign;
          done   <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          // a start arriving while done is high is taken on the following edge
          if (clk_en) begin
            angle_q <= angle[FLOAT_DATA_WIDTH-2:0];
            state   <= CONVERT;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_angle_scaler.sv
// Self-checking bench for angle_scaler: a real-arithmetic reference model drives a
// per-cycle compare process; literal vectors pin the model; delay_counter is checked standalone.
module tb_angle_scaler;

  localparam int Q_PI_2   = 1647099;
  localparam int Q_PI     = 3294199;
  localparam int Q_PI3_2  = 4941298;
  localparam int Q_TWO_PI = 6588397;

  logic        clk = 1'b0;
  logic        rst;
  logic        clk_en;
  logic [31:0] angle;
  logic [31:0] scaled;
  logic        sign;
  logic        done;

  logic        dc_rst;
  logic        dc5_done;
  logic        dc0_done;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int exp_done_cyc = -1;
  int pend_scaled = 0;
  bit pend_sign = 1'b0;
  int held_scaled = 0;
  bit held_sign = 1'b0;
  bit check_en = 1'b0;
  bit exp_d;

  always #5 clk = ~clk;

  angle_scaler dut (
    .clk   (clk),
    .rst   (rst),
    .clk_en(clk_en),
    .angle (angle),
    .scaled(scaled),
    .sign  (sign),
    .done  (done)
  );

  delay_counter #(.COUNTER_WIDTH(10)) dc5 (
    .clk (clk),
    .rst (dc_rst),
    .max (10'd5),
    .done(dc5_done)
  );

  delay_counter #(.COUNTER_WIDTH(10)) dc0 (
    .clk (clk),
    .rst (dc_rst),
    .max (10'd0),
    .done(dc0_done)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Reference: exact real value of the float, floor to Q.20, then modulo 2*pi and quadrant fold
  function automatic void modelAngle(input logic [31:0] a, output int s, output bit sg, output int lat);
    int    ex;
    int    e;
    real   v;
    longint mag;
    int    k;
    int    r;
    ex = int'(a[30:23]);
    e  = ex - 127;
    if (ex == 255 || e > 6) begin
      s = 0; sg = 1'b0; lat = 3;
      return;
    end
    if (ex == 0 || e < -24) begin
      mag = 0;
    end else begin
      v   = (1.0 + real'(a[22:0]) / 8388608.0) * (2.0 ** real'(e));
      mag = longint'($floor(v * 1048576.0));
    end
    k = int'(mag / Q_TWO_PI);
    r = int'(mag % Q_TWO_PI);
    if (r <= Q_PI_2)       begin s = r;            sg = 1'b0; end
    else if (r < Q_PI)     begin s = Q_PI - r;     sg = 1'b1; end
    else if (r <= Q_PI3_2) begin s = r - Q_PI;     sg = 1'b1; end
    else                   begin s = Q_TWO_PI - r; sg = 1'b0; end
    lat = 3 + k;
  endfunction

  // Compare process: done only in its predicted cycle, outputs held between dones
  always @(negedge clk) begin
    if (check_en) begin
      exp_d = (cyc == exp_done_cyc);
      if (exp_d) begin
        held_scaled = pend_scaled;
        held_sign   = pend_sign;
      end
      checkOutput("done", {31'b0, done}, {31'b0, exp_d});
      checkOutput("scaled", scaled, held_scaled);
      checkOutput("sign", {31'b0, sign}, {31'b0, held_sign});
    end
  end

  task automatic applyStimulus(input logic [31:0] a, input int lit_s, input int lit_sign,
                               input int lit_lat, input string tag);
    int s;
    bit sg;
    int lat;
    modelAngle(a, s, sg, lat);
    checkOutput({tag, " model scaled"}, s, lit_s);
    checkOutput({tag, " model sign"}, {31'b0, sg}, lit_sign);
    checkOutput({tag, " model latency"}, lat, lit_lat);
    @(negedge clk);
    pend_scaled  = s;
    pend_sign    = sg;
    exp_done_cyc = cyc + 1 + lat;
    angle        = a;
    clk_en       = 1'b1;
    @(negedge clk);
    clk_en = 1'b0;
    repeat (lat) @(negedge clk);
  endtask

  task automatic busyPulse();
    int s;
    bit sg;
    int lat;
    modelAngle(32'h40800000, s, sg, lat);
    @(negedge clk);
    pend_scaled  = s;
    pend_sign    = sg;
    exp_done_cyc = cyc + 1 + lat;
    angle        = 32'h40800000;
    clk_en       = 1'b1;
    @(negedge clk);
    angle = 32'h3F800000;
    @(negedge clk);
    @(negedge clk);
    clk_en = 1'b0;
    repeat (8) @(negedge clk);
  endtask

  task automatic resetMidReduce();
    @(negedge clk);
    angle        = 32'h41400000;
    clk_en       = 1'b1;
    exp_done_cyc = -1;
    @(negedge clk);
    clk_en = 1'b0;
    @(negedge clk);
    check_en = 1'b0;
    rst      = 1'b1;
    @(negedge clk);
    rst         = 1'b0;
    held_scaled = 0;
    held_sign   = 1'b0;
    check_en    = 1'b1;
    repeat (8) @(negedge clk);
  endtask

  task automatic counterTest();
    @(negedge clk);
    dc_rst = 1'b1;
    @(negedge clk);
    dc_rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      checkOutput("dc max0 done", {31'b0, dc0_done}, 32'd1);
      checkOutput("dc max5 done", {31'b0, dc5_done}, (i >= 5) ? 32'd1 : 32'd0);
      @(negedge clk);
    end
  endtask

  initial begin
    rst    = 1'b1;
    clk_en = 1'b0;
    angle  = '0;
    dc_rst = 1'b1;
    repeat (3) @(negedge clk);
    rst      = 1'b0;
    check_en = 1'b1;
    repeat (2) @(negedge clk);

    applyStimulus(32'h3F800000, 1048576, 0, 3,  "1.0");
    applyStimulus(32'h40000000, 1197047, 1, 3,  "2.0");
    applyStimulus(32'h40800000, 900105,  1, 3,  "4.0");
    applyStimulus(32'hC0E00000, 751635,  0, 4,  "-7.0");
    applyStimulus(32'h43480000, 0,       0, 3,  "200.0");
    applyStimulus(32'h7FC00000, 0,       0, 3,  "NaN");
    applyStimulus(32'h00000000, 0,       0, 3,  "zero");
    applyStimulus(32'h3FC90FD8, 1647099, 0, 3,  "PI_2");
    applyStimulus(32'h40490FDC, 0,       1, 3,  "PI");
    applyStimulus(32'h3F000000, 524288,  0, 3,  "0.5");
    applyStimulus(32'h42C80000, 556752,  0, 18, "100.0");

    resetMidReduce();
    busyPulse();
    counterTest();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
